hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's load-use hazard detector. Tracks every in-flight register write with a per-register countdown of cycles until the result is forwardable, so it handles configurable load latency, a non-pipelined multi-cycle mul/div unit, and write-after-write ordering. Sits beside the ID stage. It drives the PC write enable, the IF/ID write enable and the ID/EX bubble-select, replacing the fixed one-cycle load-use check.

---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard beside ID: per-register countdowns until a result is
// forwardable, plus mul/div occupancy, combined into one stall for PC, IF/ID and ID/EX.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wr,
  input  logic [1:0]      id_kind,
  input  logic            flush,
  output logic            stall,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            bubble,
  output logic            md_busy,
  output logic [NREG-1:0] busy_mask
);

  localparam int MAXLAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] r_mdCnt;

  logic [CW-1:0] w_lat;
  logic [CW-1:0] w_rdCnt;
  logic          w_rsBusy;
  logic          w_rtBusy;
  logic          w_gate;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_issue;

  always_comb begin
    case (id_kind)
      2'd1:    w_lat = CW'(LOAD_LAT);
      2'd2:    w_lat = CW'(MD_LAT);
      default: w_lat = '0;
    endcase
  end

  // Address decode starts at 1 so register 0 and any address >= NREG read as idle.
  always_comb begin
    w_rsBusy = 1'b0;
    w_rtBusy = 1'b0;
    w_rdCnt  = '0;
    for (int r = 1; r < NREG; r++) begin
      if (id_rs == AW'(r)) w_rsBusy = (r_cnt[r] != '0);
      if (id_rt == AW'(r)) w_rtBusy = (r_cnt[r] != '0);
      if (id_rd == AW'(r)) w_rdCnt  = r_cnt[r];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_mask[r] = (r_cnt[r] != '0);
    end
  end

  assign w_gate   = id_valid & ~flush;
  assign w_raw    = (id_use_rs & w_rsBusy) | (id_use_rt & w_rtBusy);
  assign w_waw    = id_wr & (id_rd != '0) & (w_rdCnt > w_lat);
  assign w_struct = (id_kind == 2'd2) & (r_mdCnt != '0);

  assign stall      = w_gate & (w_raw | w_waw | w_struct);
  assign w_issue    = w_gate & ~stall;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign bubble     = stall;
  assign md_busy    = (r_mdCnt != '0);

  // A fresh issue overrides the decrement of the same register on that edge.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!rst || r == 0) begin
        r_cnt[r] <= '0;
      end else if (w_issue && id_wr && id_rd == AW'(r)) begin
        r_cnt[r] <= w_lat;
      end else if (r_cnt[r] != '0) begin
        r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mdCnt <= '0;
    end else if (w_issue && id_kind == 2'd2) begin
      r_mdCnt <= CW'(MD_LAT);
    end else if (r_mdCnt != '0) begin
      r_mdCnt <= r_mdCnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance (LOAD_LAT=1, MD_LAT=4, 32 regs)
// and a swept instance (LOAD_LAT=3, MD_LAT=8, 16 regs) sharing one instruction stream.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        idValid;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUseRs;
  logic        idUseRt;
  logic [4:0]  idRd;
  logic        idWr;
  logic [1:0]  idKind;
  logic        flush;

  logic        stallA, pcWriteA, ifidWriteA, bubbleA, mdBusyA;
  logic [31:0] busyMaskA;
  logic        stallB, pcWriteB, ifidWriteB, bubbleB, mdBusyB;
  logic [15:0] busyMaskB;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .MD_LAT(4)) dutA (
    .clk(clk), .rst(rst), .id_valid(idValid),
    .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
    .id_rd(idRd), .id_wr(idWr), .id_kind(idKind), .flush(flush),
    .stall(stallA), .pc_write(pcWriteA), .ifid_write(ifidWriteA), .bubble(bubbleA),
    .md_busy(mdBusyA), .busy_mask(busyMaskA)
  );

  hazard_scoreboard #(.NREG(16), .AW(4), .LOAD_LAT(3), .MD_LAT(8)) dutB (
    .clk(clk), .rst(rst), .id_valid(idValid),
    .id_rs(idRs[3:0]), .id_rt(idRt[3:0]), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
    .id_rd(idRd[3:0]), .id_wr(idWr), .id_kind(idKind), .flush(flush),
    .stall(stallB), .pc_write(pcWriteB), .ifid_write(ifidWriteB), .bubble(bubbleB),
    .md_busy(mdBusyB), .busy_mask(busyMaskB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                               input logic wr, input logic [1:0] kind, input logic fl);
    idValid = v;
    idRs    = rs;
    idUseRs = urs;
    idRt    = rt;
    idUseRt = urt;
    idRd    = rd;
    idWr    = wr;
    idKind  = kind;
    flush   = fl;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0);
    nextCycle();
    nextCycle();
    checkOutput("reset_stall", 32'(stallA), 32'd0);
    checkOutput("reset_bubble", 32'(bubbleA), 32'd0);
    checkOutput("reset_pc_write", 32'(pcWriteA), 32'd1);
    checkOutput("reset_ifid_write", 32'(ifidWriteA), 32'd1);
    checkOutput("reset_md_busy", 32'(mdBusyA), 32'd0);
    checkOutput("reset_busy_mask", busyMaskA, 32'd0);
    checkOutput("reset_busy_mask_b", 32'(busyMaskB), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    nextCycle();

    $display("[TB] load-use");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0);
    checkOutput("lu_load_issue", 32'(stallA), 32'd0);
    nextCycle();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("lu_stall", 32'(stallA), 32'd1);
    checkOutput("lu_bubble", 32'(bubbleA), 32'd1);
    checkOutput("lu_pc_write", 32'(pcWriteA), 32'd0);
    checkOutput("lu_ifid_write", 32'(ifidWriteA), 32'd0);
    checkOutput("lu_busy_mask", busyMaskA, 32'h0000_0020);
    nextCycle();
    checkOutput("lu_release", 32'(stallA), 32'd0);
    checkOutput("lu_mask_clear", busyMaskA, 32'd0);
    nextCycle();

    $display("[TB] mul/div structural and RAW");
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0);
    checkOutput("md_first_issue", 32'(stallA), 32'd0);
    checkOutput("md_idle_before", 32'(mdBusyA), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 2, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("md_struct_stall_%0d", i), 32'(stallA), 32'd1);
      checkOutput($sformatf("md_busy_%0d", i), 32'(mdBusyA), 32'd1);
      nextCycle();
    end
    checkOutput("md_struct_release", 32'(stallA), 32'd0);
    checkOutput("md_busy_release", 32'(mdBusyA), 32'd0);
    nextCycle();
    applyStimulus(1, 9, 1, 0, 0, 10, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("md_raw_stall_%0d", i), 32'(stallA), 32'd1);
      checkOutput($sformatf("md_raw_mask_%0d", i), busyMaskA, 32'h0000_0200);
      nextCycle();
    end
    checkOutput("md_raw_release", 32'(stallA), 32'd0);
    nextCycle();

    $display("[TB] write-after-write");
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0);
    checkOutput("waw_mul_issue", 32'(stallA), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 1, 2, 1, 8, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("waw_stall_%0d", i), 32'(stallA), 32'd1);
      checkOutput($sformatf("waw_mask_%0d", i), busyMaskA, 32'h0000_0100);
      nextCycle();
    end
    checkOutput("waw_release", 32'(stallA), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_alu_leaves_zero", busyMaskA, 32'd0);

    $display("[TB] load behind mul to same register");
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lw_stall_%0d", i), 32'(stallA), 32'd1);
      nextCycle();
    end
    checkOutput("lw_release", 32'(stallA), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_load_wins", busyMaskA, 32'h0000_0100);
    nextCycle();
    checkOutput("lw_drained", busyMaskA, 32'd0);

    $display("[TB] register 0");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("r0_load_issue", 32'(stallA), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 1, 3, 1, 0, 0);
    checkOutput("r0_reader", 32'(stallA), 32'd0);
    checkOutput("r0_mask", busyMaskA, 32'd0);
    nextCycle();

    $display("[TB] flush");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 5, 1, 0, 0, 12, 1, 2, 1);
    checkOutput("flush_stall", 32'(stallA), 32'd0);
    checkOutput("flush_pc_write", 32'(pcWriteA), 32'd1);
    checkOutput("flush_bubble", 32'(bubbleA), 32'd0);
    checkOutput("flush_mask", busyMaskA, 32'h0000_0020);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_no_issue_mask", busyMaskA, 32'd0);
    checkOutput("flush_no_issue_md", 32'(mdBusyA), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_pending", busyMaskA, 32'h0000_0100);
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 8, 1, 0, 0, 6, 1, 0, 0);
    checkOutput("midrst_stall", 32'(stallA), 32'd0);
    checkOutput("midrst_mask", busyMaskA, 32'd0);
    checkOutput("midrst_md_busy", 32'(mdBusyA), 32'd0);
    nextCycle();

    $display("[TB] parameter sweep instance");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0);
    checkOutput("sw_load_issue", 32'(stallB), 32'd0);
    nextCycle();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sw_lu_stall_%0d", i), 32'(stallB), 32'd1);
      checkOutput($sformatf("sw_lu_mask_%0d", i), 32'(busyMaskB), 32'h0000_0020);
      nextCycle();
    end
    checkOutput("sw_lu_release", 32'(stallB), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0);
    nextCycle();
    applyStimulus(1, 8, 1, 0, 0, 6, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("sw_md_stall_%0d", i), 32'(stallB), 32'd1);
      checkOutput($sformatf("sw_md_busy_%0d", i), 32'(mdBusyB), 32'd1);
      nextCycle();
    end
    checkOutput("sw_md_release", 32'(stallB), 32'd0);
    checkOutput("sw_md_idle", 32'(mdBusyB), 32'd0);
    checkOutput("sw_pc_write", 32'(pcWriteB), 32'd1);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
